ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter_pkg.sv | 17 +
 rtl/arb_starve_cnt.sv | 38 +++
 rtl/ram_port_arbiter.sv | 94 +++++++++
 tb/tb_ram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: response-owner encoding,
// bus widths and the legal range of the starvation limit.
package ram_port_arbiter_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 4;
  localparam int STARVE_MIN = 1;
  localparam int STARVE_MAX = 15;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_IF   = 2'b01,
    OWNER_MEM  = 2'b10
  } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter for bus arbiters: counts up on inc, clears on
// clr (clear wins), stops at limit and flags when the limit has been reached.
module arb_starve_cnt
  import ram_port_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         limit_hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_hit = (count_q == limit);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single synchronous data RAM port between instruction fetch and
// the MEM stage; MEM has priority, a starvation counter guarantees fetch progress.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  owner_e resp_owner_q;
  owner_e resp_owner_d;
  logic   grant_if;
  logic   grant_mem;
  logic   limit_hit;
  logic   cnt_inc;
  logic   cnt_clr;

  // Fetch only beats a competing MEM request once it has waited STARVE_LIMIT grants.
  always_comb begin
    grant_if  = if_req && (!mem_req || limit_hit);
    grant_mem = mem_req && !grant_if;
    cnt_inc   = grant_mem && if_req;
    cnt_clr   = grant_if || !if_req;
  end

  always_comb begin
    ram_en       = 1'b0;
    ram_wen      = 4'b0000;
    ram_addr     = '0;
    ram_wdata    = '0;
    resp_owner_d = OWNER_NONE;
    if (grant_mem) begin
      ram_en    = 1'b1;
      ram_wen   = mem_wen;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
      if (mem_wen == 4'b0000) begin
        resp_owner_d = OWNER_MEM;
      end
    end else if (grant_if) begin
      ram_en       = 1'b1;
      ram_addr     = if_addr;
      resp_owner_d = OWNER_IF;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_owner_q <= OWNER_NONE;
    end else begin
      resp_owner_q <= resp_owner_d;
    end
  end

  arb_starve_cnt #(
    .W(CNT_W)
  ) u_starve_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .limit    (LIMIT),
    .limit_hit(limit_hit)
  );

  assign if_ack     = grant_if;
  assign mem_ack    = grant_mem;
  assign if_rvalid  = (resp_owner_q == OWNER_IF);
  assign mem_rvalid = (resp_owner_q == OWNER_MEM);
  assign if_rdata   = ram_rdata;
  assign mem_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM whose read data
// is the issued address XOR 0x5A5A0000, returned one cycle after the read.
module tb_ram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int tests_run;
  int tests_failed;

  ram_port_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .ram_en    (ram_en),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ram_rdata = 32'h0;
  always @(posedge clk) begin
    if (ram_en && ram_wen == 4'b0000) begin
      ram_rdata <= ram_addr ^ 32'h5A5A_0000;
    end
  end

  task automatic drive_inputs(input logic ir, input logic [31:0] ia, input logic mr,
                              input logic [3:0] mw, input logic [31:0] ma,
                              input logic [31:0] md);
    @(negedge clk);
    if_req    = ir;
    if_addr   = ia;
    mem_req   = mr;
    mem_wen   = mw;
    mem_addr  = ma;
    mem_wdata = md;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    tests_run++;
    if ({if_ack, mem_ack, ram_en, ram_wen} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_comb: got ack/en/wen %b want 0", {if_ack, mem_ack, ram_en, ram_wen});
    end
    tests_run++;
    if ({if_rvalid, mem_rvalid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_rvalid: got %b want 00", {if_rvalid, mem_rvalid});
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_fetch_only;
    for (int c = 1; c <= 3; c++) begin
      drive_inputs(1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0);
      tests_run++;
      if ({if_ack, mem_ack, ram_en, ram_wen} !== 7'b1010000 || ram_addr !== 32'h100) begin
        tests_failed++;
        $display("[TB] FAIL fetch_grant c%0d: got ack/en/wen %b addr %h want 1010000 addr 00000100",
                 c, {if_ack, mem_ack, ram_en, ram_wen}, ram_addr);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({if_rvalid, mem_rvalid} !== 2'b10 || if_rdata !== 32'h5A5A_0100) begin
        tests_failed++;
        $display("[TB] FAIL fetch_rvalid c%0d: got %b data %h want 10 data 5a5a0100",
                 c, {if_rvalid, mem_rvalid}, if_rdata);
      end
    end
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    tests_run++;
    if ({if_rvalid, mem_rvalid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL fetch_idle: got %b want 00", {if_rvalid, mem_rvalid});
    end
  endtask

  task automatic test_contention;
    for (int c = 1; c <= 6; c++) begin
      logic exp_f;
      exp_f = (c == 5);
      drive_inputs(1'b1, 32'h104, 1'b1, 4'h0, 32'h200, 32'h0);
      tests_run++;
      if (if_ack !== exp_f || mem_ack !== !exp_f || ram_addr !== (exp_f ? 32'h104 : 32'h200)) begin
        tests_failed++;
        $display("[TB] FAIL contend_grant c%0d: got if/mem %b%b addr %h want %b%b addr %h",
                 c, if_ack, mem_ack, ram_addr, exp_f, !exp_f, exp_f ? 32'h104 : 32'h200);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({if_rvalid, mem_rvalid} !== {exp_f, !exp_f} ||
          (exp_f ? if_rdata : mem_rdata) !== (exp_f ? 32'h5A5A_0104 : 32'h5A5A_0200)) begin
        tests_failed++;
        $display("[TB] FAIL contend_rvalid c%0d: got %b want %b%b", c,
                 {if_rvalid, mem_rvalid}, exp_f, !exp_f);
      end
    end
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_mem_store;
    drive_inputs(1'b0, 32'h0, 1'b1, 4'b0100, 32'h203, 32'h00AB_0000);
    tests_run++;
    if ({mem_ack, if_ack, ram_en, ram_wen} !== 7'b1010100 ||
        ram_addr !== 32'h203 || ram_wdata !== 32'h00AB_0000) begin
      tests_failed++;
      $display("[TB] FAIL store_issue: got ack/en/wen %b addr %h wdata %h want 1010100 00000203 00ab0000",
               {mem_ack, if_ack, ram_en, ram_wen}, ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({if_rvalid, mem_rvalid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL store_no_rvalid: got %b want 00", {if_rvalid, mem_rvalid});
    end
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    addrs = '{32'h300, 32'h140, 32'h304, 32'h144};
    for (int c = 0; c < 4; c++) begin
      logic is_f;
      is_f = c[0];
      drive_inputs(is_f, addrs[c], !is_f, 4'h0, addrs[c], 32'h0);
      tests_run++;
      if ({if_ack, mem_ack} !== {is_f, !is_f}) begin
        tests_failed++;
        $display("[TB] FAIL alt_grant c%0d: got %b%b want %b%b", c, if_ack, mem_ack, is_f, !is_f);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({if_rvalid, mem_rvalid} !== {is_f, !is_f} ||
          (is_f ? if_rdata : mem_rdata) !== (addrs[c] ^ 32'h5A5A_0000)) begin
        tests_failed++;
        $display("[TB] FAIL alt_rvalid c%0d: got %b data %h want %b%b data %h", c,
                 {if_rvalid, mem_rvalid}, is_f ? if_rdata : mem_rdata, is_f, !is_f,
                 addrs[c] ^ 32'h5A5A_0000);
      end
    end
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read;
    for (int c = 1; c <= 2; c++) begin
      drive_inputs(1'b1, 32'h108, 1'b1, 4'h0, 32'h208, 32'h0);
      @(posedge clk); #1;
    end
    drive_inputs(1'b1, 32'h108, 1'b1, 4'h0, 32'h300, 32'h0);
    tests_run++;
    if (mem_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_read_ack: got %b want 1", mem_ack);
    end
    resetn = 1'b0;
    if_req = 1'b0;
    mem_req = 1'b0;
    #1;
    tests_run++;
    if ({if_rvalid, mem_rvalid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rst_async_clear: got %b want 00", {if_rvalid, mem_rvalid});
    end
    @(posedge clk); #1;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({if_rvalid, mem_rvalid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rst_discard: got %b want 00", {if_rvalid, mem_rvalid});
    end
    for (int c = 1; c <= 5; c++) begin
      drive_inputs(1'b1, 32'h10C, 1'b1, 4'h0, 32'h20C, 32'h0);
      tests_run++;
      if (if_ack !== (c == 5)) begin
        tests_failed++;
        $display("[TB] FAIL rst_cnt_clear c%0d: got if_ack %b want %b", c, if_ack, c == 5);
      end
      @(posedge clk); #1;
    end
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_if_drop;
    for (int c = 1; c <= 3; c++) begin
      drive_inputs(1'b1, 32'h110, 1'b1, 4'h0, 32'h210, 32'h0);
      @(posedge clk); #1;
    end
    drive_inputs(1'b0, 32'h0, 1'b1, 4'h0, 32'h214, 32'h0);
    tests_run++;
    if (mem_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_mem_ack: got %b want 1", mem_ack);
    end
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      drive_inputs(1'b1, 32'h118, 1'b1, 4'h0, 32'h218, 32'h0);
      tests_run++;
      if (if_ack !== (c == 5) || mem_ack !== (c != 5)) begin
        tests_failed++;
        $display("[TB] FAIL drop_regrant c%0d: got if/mem %b%b want %b%b", c,
                 if_ack, mem_ack, c == 5, c != 5);
      end
      @(posedge clk); #1;
    end
    drive_inputs(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn    = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_req   = 1'b0;
    mem_wen   = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    test_reset();
    test_fetch_only();
    test_contention();
    test_mem_store();
    test_back_to_back();
    test_reset_mid_read();
    test_if_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
